// File: rtl/systolic_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_feeder -- row-vector FIFO plus skewed lane pipeline feeding a
// systolic array one tile of k_len vectors at a time.   Rev 1.0
// ----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int DATAWITH   = 16,
  parameter int ARRAY_SIZE = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR       = 3
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           wr_valid,
  input  logic [ARRAY_SIZE*DATAWITH-1:0] wr_data,
  output logic                           wr_ready,
  input  logic                           start,
  input  logic [7:0]                     k_len,
  output logic [ARRAY_SIZE*DATAWITH-1:0] data_out,
  output logic [ARRAY_SIZE-1:0]          lane_valid,
  output logic                           systolic_en,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR:0]                  fifo_count
);

  localparam int            VW        = ARRAY_SIZE * DATAWITH;
  localparam logic [ADDR:0] FULL_CNT  = (ADDR+1)'(DEPTH);
  localparam logic [3:0]    DRAIN_LEN = 4'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [3:0]    drain_q, drain_d;
  logic          en_q;

  logic [VW-1:0] mem_q [DEPTH];
  logic [ADDR-1:0] wptr_q, rptr_q;
  logic [ADDR:0] count_q;
  logic [VW-1:0] rd_vec;

  logic push;
  logic pop;
  logic shift;

  assign wr_ready   = (count_q != FULL_CNT);
  assign fifo_count = count_q;
  assign push       = wr_valid && wr_ready;
  assign rd_vec     = mem_q[rptr_q];
  assign shift      = pop || (state_q == DRAIN);

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign systolic_en = en_q;

  // Pop decision uses the registered count, so a vector written this cycle
  // cannot be read until the next one.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drain_d = drain_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = k_len;
          state_d = (k_len != 8'd0) ? FEED : FIN;
        end
      end
      FEED: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = DRAIN;
            drain_d = DRAIN_LEN;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - 4'd1;
        if (drain_q == 4'd1) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      drain_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      en_q    <= shift;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + ADDR'(1);
      if (pop)  rptr_q <= rptr_q + ADDR'(1);
      if (push && !pop)      count_q <= count_q + (ADDR+1)'(1);
      else if (!push && pop) count_q <= count_q - (ADDR+1)'(1);
    end
  end

  // Lane i is i+1 stages deep; DRAIN shifts push zero/invalid into stage 0.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATAWITH-1:0] data_q [0:i];
    logic [i:0]          vld_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int j = 0; j <= i; j++) data_q[j] <= '0;
        vld_q <= '0;
      end else if (shift) begin
        data_q[0] <= pop ? rd_vec[i*DATAWITH +: DATAWITH] : '0;
        vld_q[0]  <= pop;
        for (int j = 1; j <= i; j++) begin
          data_q[j] <= data_q[j-1];
          vld_q[j]  <= vld_q[j-1];
        end
      end
    end

    assign data_out[i*DATAWITH +: DATAWITH] = data_q[i];
    assign lane_valid[i]                    = vld_q[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_systolic_feeder -- directed tile scenarios with a per-lane scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int DW = 16;
  localparam int AS = 4;
  localparam int DP = 8;
  localparam int AW = 3;

  logic             clk      = 1'b0;
  logic             rstn     = 1'b0;
  logic             wr_valid = 1'b0;
  logic [AS*DW-1:0] wr_data  = '0;
  logic             start    = 1'b0;
  logic [7:0]       k_len    = '0;
  logic             wr_ready;
  logic [AS*DW-1:0] data_out;
  logic [AS-1:0]    lane_valid;
  logic             systolic_en;
  logic             busy;
  logic             done;
  logic [AW:0]      fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] exp_q    [AS][$];
  int            emit_cyc [AS][$];

  systolic_feeder #(
    .DATAWITH  (DW),
    .ARRAY_SIZE(AS),
    .DEPTH     (DP),
    .ADDR      (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .start      (start),
    .k_len      (k_len),
    .data_out   (data_out),
    .lane_valid (lane_valid),
    .systolic_en(systolic_en),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AS*DW-1:0] mk(input int id);
    logic [AS*DW-1:0] v;
    for (int i = 0; i < AS; i++) v[i*DW +: DW] = DW'(16 * id + i);
    return v;
  endfunction

  function automatic void sb_push(input int id);
    logic [AS*DW-1:0] v;
    v = mk(id);
    for (int i = 0; i < AS; i++) exp_q[i].push_back(v[i*DW +: DW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic sb_empty(input string tag);
    for (int i = 0; i < AS; i++) check($sformatf("%s_lane%0d_left", tag, i), exp_q[i].size(), 0);
  endtask

  // Length counts the start cycle and the done cycle inclusively.
  task automatic wait_done(input int n0, input int exp_len, input string tag);
    int n;
    n = 0;
    sample();
    while (done !== 1'b1 && n < 80) begin
      sample();
      n++;
    end
    check({tag, "_len"}, cyc - n0 + 1, exp_len);
    check({tag, "_busy_fin"}, busy, 1);
    sample();
    check({tag, "_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (rstn && systolic_en) begin
      for (int i = 0; i < AS; i++) begin
        if (lane_valid[i]) begin
          logic [DW-1:0] e;
          if (exp_q[i].size() != 0) e = exp_q[i].pop_front();
          else                      e = 'x;
          check($sformatf("lane%0d_data", i), data_out[i*DW +: DW], e);
          emit_cyc[i].push_back(cyc);
        end
      end
    end
  end

  initial begin
    int n0;
    logic [AS*DW-1:0] held;
    logic [6:0] en_pat;

    // Reset values
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_data", data_out, 0);
    check("rst_valid", lane_valid, 0);
    check("rst_flags", {systolic_en, busy, done}, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Basic 3-vector tile
    for (int v = 0; v < 3; v++) begin
      wr_valid = 1'b1;
      wr_data  = mk(v);
      sb_push(v);
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < AS; i++) emit_cyc[i].delete();
    n0 = cyc; start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    wait_done(n0, 8, "t1");
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t1_lane0_cyc%0d", k), (emit_cyc[0].size() > k) ? emit_cyc[0][k] : -1, n0 + 2 + k);
      check($sformatf("t1_lane3_cyc%0d", k), (emit_cyc[3].size() > k) ? emit_cyc[3][k] : -1, n0 + 5 + k);
    end
    sb_empty("t1");
    tick();

    // k_len = 0 with one vector stored
    wr_valid = 1'b1; wr_data = mk(3); sb_push(3);
    tick();
    wr_valid = 1'b0;
    n0 = cyc; start = 1'b1; k_len = 8'd0;
    tick();
    start = 1'b0;
    sample();
    check("k0_done", done, 1);
    check("k0_busy", busy, 1);
    check("k0_count", fifo_count, 1);
    tick();
    sample();
    check("k0_done_end", done, 0);
    check("k0_busy_end", busy, 0);
    check("k0_count_end", fifo_count, 1);
    tick();

    // Stalled tile: 2 stored, 2 more arrive later
    wr_valid = 1'b1; wr_data = mk(4); sb_push(4);
    tick();
    wr_valid = 1'b0;
    n0 = cyc; start = 1'b1; k_len = 8'd4;
    tick();
    start = 1'b0;
    en_pat = 7'b1001100;
    held = '0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 4)      begin wr_valid = 1'b1; wr_data = mk(5); sb_push(5); end
      else if (c == 5) begin wr_valid = 1'b1; wr_data = mk(6); sb_push(6); end
      else             wr_valid = 1'b0;
      sample();
      check($sformatf("stall_en_c%0d", c), systolic_en, en_pat[c]);
      if (c == 3) held = data_out;
      if (c == 4 || c == 5) check($sformatf("stall_hold_c%0d", c), data_out, held);
      tick();
    end
    wr_valid = 1'b0;
    wait_done(n0, 11, "stall");
    sb_empty("stall");
    tick();

    // Fill to full, ninth push refused, then drain
    for (int j = 0; j < 9; j++) begin
      wr_valid = 1'b1;
      wr_data  = mk(7 + j);
      sample();
      check($sformatf("full_ready_%0d", j), wr_ready, (j < 8) ? 1 : 0);
      check($sformatf("full_count_%0d", j), fifo_count, (j < 8) ? j : 8);
      if (j < 8) sb_push(7 + j);
      tick();
    end
    wr_valid = 1'b0;
    sample();
    check("full_count_end", fifo_count, 8);
    check("full_ready_end", wr_ready, 0);
    tick();
    n0 = cyc; start = 1'b1; k_len = 8'd8;
    tick();
    start = 1'b0;
    sample();
    check("full_ready_prepop", wr_ready, 0);
    tick();
    sample();
    check("full_ready_postpop", wr_ready, 1);
    check("full_count_postpop", fifo_count, 7);
    wait_done(n0, 13, "full");
    sb_empty("full");
    tick();

    // 20 vectors with pushes during FEED and an ignored second start
    for (int j = 0; j < 8; j++) begin
      wr_valid = 1'b1; wr_data = mk(16 + j); sb_push(16 + j);
      tick();
    end
    wr_valid = 1'b0;
    n0 = cyc; start = 1'b1; k_len = 8'd20;
    tick();
    start = 1'b0;
    sample();
    check("wrap_ready_full", wr_ready, 0);
    tick();
    for (int j = 0; j < 12; j++) begin
      wr_valid = 1'b1;
      wr_data  = mk(24 + j);
      sb_push(24 + j);
      start = (j == 3);
      k_len = (j == 3) ? 8'd5 : 8'd0;
      sample();
      check($sformatf("wrap_ready_%0d", j), wr_ready, 1);
      tick();
    end
    wr_valid = 1'b0;
    start    = 1'b0;
    wait_done(n0, 25, "wrap");
    sb_empty("wrap");
    check("wrap_count_end", fifo_count, 0);
    tick();

    // Reset in the middle of DRAIN
    for (int j = 0; j < 3; j++) begin
      wr_valid = 1'b1; wr_data = mk(40 + j); sb_push(40 + j);
      tick();
    end
    wr_valid = 1'b0;
    n0 = cyc; start = 1'b1; k_len = 8'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_in_drain", busy, 1);
    rstn = 1'b0;
    for (int i = 0; i < AS; i++) exp_q[i].delete();
    #1;
    check("abort_data", data_out, 0);
    check("abort_valid", lane_valid, 0);
    check("abort_flags", {systolic_en, busy, done}, 0);
    check("abort_count", fifo_count, 0);
    check("abort_ready", wr_ready, 1);
    for (int c = 0; c < 2; c++) begin
      sample();
      check($sformatf("abort_nodone_%0d", c), done, 0);
    end
    tick();
    rstn = 1'b1;
    sample();
    check("post_rst_done", done, 0);
    check("post_rst_count", fifo_count, 0);
    tick();
    wr_valid = 1'b1; wr_data = mk(50); sb_push(50);
    tick();
    wr_valid = 1'b0;
    n0 = cyc; start = 1'b1; k_len = 8'd1;
    tick();
    start = 1'b0;
    wait_done(n0, 6, "post_rst");
    sb_empty("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
